// File: rtl/hc21_ste_bus_decoder.sv
// rtl/hc21_ste_bus_decoder.sv - HC21-STE memory map decoder and bus-cycle sequencer
//
// Decodes the Z80 page address into lomem / STEbus / I/O slot / himem selects,
// qualifies them with the CPU memory cycle, inserts per-region wait states and
// runs the STEbus DATACK handshake with a timeout.
//
// Ports:
//   sysclk        system clock, rising edge
//   sysrst        asynchronous active-high reset
//   cpu_addr      CPU address bus A15:0
//   cpu_mreq_n    CPU memory request, active low
//   cpu_rd_n      CPU read strobe, active low
//   cpu_wr_n      CPU write strobe, active low
//   ste_datack_n  STEbus data acknowledge, active low
//   sel_lomem_n   low memory select, active low
//   sel_stebus_n  STEbus window select, active low
//   sel_himem_n   high memory select, active low
//   sel_io_n      I/O slot selects, active low, bit n = slot n
//   cpu_wait_n    CPU WAIT, active low
//   bus_timeout   one-cycle pulse when DATACK never arrives

module hc21_ste_bus_decoder #(
  parameter logic [7:0] LOMEM_TOP = 8'h3F,
  parameter logic [7:0] STE_TOP   = 8'hBF,
  parameter logic [7:0] IO_PAGE   = 8'hC0,
  parameter int         NUM_DEV   = 8,
  parameter int         LOMEM_WS  = 0,
  parameter int         HIMEM_WS  = 0,
  parameter int         IO_WS     = 1,
  parameter int         STE_WS    = 2,
  parameter int         STE_TMO   = 64
) (
  input  logic               sysclk,
  input  logic               sysrst,
  input  logic [15:0]        cpu_addr,
  input  logic               cpu_mreq_n,
  input  logic               cpu_rd_n,
  input  logic               cpu_wr_n,
  input  logic               ste_datack_n,
  output logic               sel_lomem_n,
  output logic               sel_stebus_n,
  output logic               sel_himem_n,
  output logic [NUM_DEV-1:0] sel_io_n,
  output logic               cpu_wait_n,
  output logic               bus_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STEACK, ST_HOLD} state_t;
  typedef enum logic [1:0] {RG_LOMEM, RG_STE, RG_IO, RG_HIMEM} region_t;

  localparam logic [7:0] TMO_LAST = 8'(STE_TMO - 1);

  state_t       state_q, state_d;
  region_t      region_q, region_d;
  logic [3:0]   ws_cnt_q, ws_cnt_d;
  logic [7:0]   tmo_cnt_q, tmo_cnt_d;
  logic         lo_d, ste_d, hi_d, wait_d, tmo_pulse_d;
  logic [NUM_DEV-1:0] io_d;

  logic [7:0]   page;
  logic [3:0]   slot;
  logic         cycle_start;
  region_t      dec_region;
  logic [3:0]   dec_ws;
  logic [NUM_DEV-1:0] dec_io;
  logic         release_all;

  assign page        = cpu_addr[15:8];
  assign slot        = cpu_addr[7:4];
  assign cycle_start = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);

  // Live decode of the current address; only consumed on the IDLE edge that
  // starts a cycle, so later address movement cannot disturb the selects.
  always_comb begin
    dec_region = RG_HIMEM;
    dec_ws     = 4'(HIMEM_WS);
    dec_io     = '0;
    if (page <= LOMEM_TOP) begin
      dec_region = RG_LOMEM;
      dec_ws     = 4'(LOMEM_WS);
    end else if (page <= STE_TOP) begin
      dec_region = RG_STE;
      dec_ws     = 4'(STE_WS);
    end else if (page == IO_PAGE && {1'b0, slot} < 5'(NUM_DEV)) begin
      dec_region = RG_IO;
      dec_ws     = 4'(IO_WS);
      for (int i = 0; i < NUM_DEV; i++) begin
        if (slot == 4'(i)) dec_io[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    ws_cnt_d    = ws_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    lo_d        = sel_lomem_n;
    ste_d       = sel_stebus_n;
    hi_d        = sel_himem_n;
    io_d        = sel_io_n;
    wait_d      = cpu_wait_n;
    tmo_pulse_d = 1'b0;
    release_all = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cycle_start) begin
          region_d  = dec_region;
          ws_cnt_d  = dec_ws;
          tmo_cnt_d = 8'd0;
          lo_d      = (dec_region != RG_LOMEM);
          ste_d     = (dec_region != RG_STE);
          hi_d      = (dec_region != RG_HIMEM);
          io_d      = ~dec_io;
          if (dec_ws != 4'd0) begin
            state_d = ST_WAIT;
            wait_d  = 1'b0;
          end else if (dec_region == RG_STE) begin
            state_d = ST_STEACK;
            wait_d  = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (cpu_mreq_n) begin
          release_all = 1'b1;
        end else begin
          ws_cnt_d = ws_cnt_q - 4'd1;
          if (ws_cnt_q == 4'd1) begin
            // STE keeps WAIT asserted into the handshake; DATACK seen on
            // this edge is deliberately ignored.
            if (region_q == RG_STE) begin
              state_d   = ST_STEACK;
              tmo_cnt_d = 8'd0;
            end else begin
              state_d = ST_HOLD;
              wait_d  = 1'b1;
            end
          end
        end
      end
      ST_STEACK: begin
        if (cpu_mreq_n) begin
          release_all = 1'b1;
        end else if (!ste_datack_n) begin
          state_d = ST_HOLD;
          wait_d  = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = ST_HOLD;
          wait_d      = 1'b1;
          tmo_pulse_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (cpu_mreq_n) release_all = 1'b1;
      end
      default: release_all = 1'b1;
    endcase

    if (release_all) begin
      state_d   = ST_IDLE;
      ws_cnt_d  = 4'd0;
      tmo_cnt_d = 8'd0;
      lo_d      = 1'b1;
      ste_d     = 1'b1;
      hi_d      = 1'b1;
      io_d      = '1;
      wait_d    = 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      state_q      <= ST_IDLE;
      region_q     <= RG_HIMEM;
      ws_cnt_q     <= 4'd0;
      tmo_cnt_q    <= 8'd0;
      sel_lomem_n  <= 1'b1;
      sel_stebus_n <= 1'b1;
      sel_himem_n  <= 1'b1;
      sel_io_n     <= '1;
      cpu_wait_n   <= 1'b1;
      bus_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      ws_cnt_q     <= ws_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      sel_lomem_n  <= lo_d;
      sel_stebus_n <= ste_d;
      sel_himem_n  <= hi_d;
      sel_io_n     <= io_d;
      cpu_wait_n   <= wait_d;
      bus_timeout  <= tmo_pulse_d;
    end
  end

endmodule
